// File: rtl/ozone_pkg.sv
// Shared types, default geometry and derived widths for the uop issue queue.
package ozone_pkg;

    localparam int unsigned UOPQ_DEPTH = 16;
    localparam int unsigned UOPQ_ENQ_W = 4;
    localparam int unsigned UOPQ_DEQ_W = 2;
    localparam int unsigned UOPQ_PTR_W = $clog2(UOPQ_DEPTH);
    localparam int unsigned UOPQ_CNT_W = $clog2(UOPQ_DEPTH + 1);

    typedef enum logic [1:0] {
        UOP_ALU  = 2'd0,
        UOP_MEM  = 2'd1,
        UOP_BR   = 2'd2,
        UOP_MISC = 2'd3
    } uop_class_e;

    typedef struct packed {
        logic [31:0] pc;
        uop_class_e  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } uop_insn;

    localparam int unsigned UOP_W = $bits(uop_insn);

endpackage

// File: rtl/uopq_ram.sv
// Issue queue storage: DEPTH entries, ENQ_W write ports, DEQ_W asynchronous read ports.
module uopq_ram
    import ozone_pkg::*;
#(
    parameter int unsigned DEPTH = UOPQ_DEPTH,
    parameter int unsigned ENQ_W = UOPQ_ENQ_W,
    parameter int unsigned DEQ_W = UOPQ_DEQ_W,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                          clk_in,
    input  logic [ENQ_W-1:0]              wr_en_in,
    input  logic [ENQ_W-1:0][PTR_W-1:0]   wr_addr_in,
    input  uop_insn [ENQ_W-1:0]           wr_data_in,
    input  logic [DEQ_W-1:0][PTR_W-1:0]   rd_addr_in,
    output uop_insn [DEQ_W-1:0]           rd_data_out
);

    uop_insn mem_q [DEPTH];

    // Write addresses are distinct by construction, so ports never collide.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < int'(ENQ_W); i++) begin
            if (wr_en_in[i]) begin
                mem_q[wr_addr_in[i]] <= wr_data_in[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEQ_W); i++) begin
            rd_data_out[i] = mem_q[rd_addr_in[i]];
        end
    end

endmodule

// File: rtl/uop_issue_queue.sv
// In-order decode-to-issue FIFO with multi-lane enqueue/dequeue and mispredict flush.
// Optional occupancy/stall statistics are built when UOPQ_STATS_EN is defined.
module uop_issue_queue
    import ozone_pkg::*;
#(
    parameter int unsigned DEPTH = UOPQ_DEPTH,
    parameter int unsigned ENQ_W = UOPQ_ENQ_W,
    parameter int unsigned DEQ_W = UOPQ_DEQ_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 flush_in,
    input  logic [ENQ_W-1:0]     enq_valid_in,
    input  uop_insn [ENQ_W-1:0]  enq_uops_in,
    output logic                 enq_ready_out,
    output logic [DEQ_W-1:0]     deq_valid_out,
    output uop_insn [DEQ_W-1:0]  deq_uops_out,
    input  logic                 deq_ready_in,
    output logic [CNT_W-1:0]     count_out,
    output logic [CNT_W-1:0]     hwm_out,
    output logic [31:0]          stall_cyc_out
);

    localparam int unsigned EN_W = $clog2(ENQ_W + 1);
    localparam int unsigned DN_W = $clog2(DEQ_W + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             enq_fire;
    logic             enq_take;
    logic             run;
    logic [EN_W-1:0]  n_enq;
    logic [DN_W-1:0]  n_deq;

    logic [ENQ_W-1:0]            wr_en;
    logic [ENQ_W-1:0][PTR_W-1:0] wr_addr;
    logic [DEQ_W-1:0][PTR_W-1:0] rd_addr;
    uop_insn [DEQ_W-1:0]         rd_data;

    // Ready looks only at registered occupancy, never at the same-cycle dequeue.
    assign enq_ready_out = (DEPTH - 32'(count_q)) >= ENQ_W;
    assign enq_fire      = enq_ready_out && enq_valid_in[0];
    assign enq_take      = enq_fire && !flush_in;
    assign count_out     = count_q;

    always_comb begin
        deq_valid_out = '0;
        for (int i = 0; i < int'(DEQ_W); i++) begin
            deq_valid_out[i] = !flush_in && (int'(count_q) > i);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEQ_W); i++) begin
            rd_addr[i]      = head_q + PTR_W'(i);
            deq_uops_out[i] = deq_valid_out[i] ? rd_data[i] : '0;
        end
    end

    // Only the leading run of valid lanes is accepted.
    always_comb begin
        n_enq = '0;
        run   = 1'b1;
        for (int i = 0; i < int'(ENQ_W); i++) begin
            run = run & enq_valid_in[i];
            if (run && enq_fire) begin
                n_enq = n_enq + EN_W'(1);
            end
        end
    end

    always_comb begin
        n_deq = '0;
        if (deq_ready_in) begin
            for (int i = 0; i < int'(DEQ_W); i++) begin
                if (deq_valid_out[i]) begin
                    n_deq = n_deq + DN_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(ENQ_W); i++) begin
            wr_addr[i] = tail_q + PTR_W'(i);
            wr_en[i]   = enq_take && (i < int'(n_enq));
        end
    end

    // Flush wins over any same-cycle enqueue/dequeue.
    always_comb begin
        head_d  = head_q + PTR_W'(n_deq);
        tail_d  = tail_q + PTR_W'(n_enq);
        count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    uopq_ram #(
        .DEPTH (DEPTH),
        .ENQ_W (ENQ_W),
        .DEQ_W (DEQ_W)
    ) u_ram (
        .clk_in      (clk_in),
        .wr_en_in    (wr_en),
        .wr_addr_in  (wr_addr),
        .wr_data_in  (enq_uops_in),
        .rd_addr_in  (rd_addr),
        .rd_data_out (rd_data)
    );

`ifdef UOPQ_STATS_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;
    logic [31:0]      stall_q, stall_d;

    // High-water mark tracks next occupancy so it moves together with count_out.
    always_comb begin
        hwm_d   = hwm_q;
        stall_d = stall_q;
        if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
        if (enq_valid_in[0] && !enq_ready_out && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hwm_q   <= '0;
            stall_q <= '0;
        end else begin
            hwm_q   <= hwm_d;
            stall_q <= stall_d;
        end
    end

    assign hwm_out       = hwm_q;
    assign stall_cyc_out = stall_q;
`else
    assign hwm_out       = '0;
    assign stall_cyc_out = '0;
`endif

    a_enq_prefix: assert property (@(posedge clk_in) disable iff (rst_in)
        ((enq_valid_in & (enq_valid_in + ENQ_W'(1))) == '0));

endmodule
